// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with mul/div wait FSM and watchdog
// Optional stall-cycle performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7,
  parameter int PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_ID,
  input  logic [4:0]        rs2_ID,
  input  logic              rs1_used_ID,
  input  logic              rs2_used_ID,
  input  logic [4:0]        rd_EX,
  input  logic              mem_read_EX,
  input  logic              redirect_EX,
  input  logic              md_start_EX,
  input  logic              md_done,
  input  logic              imem_ready,
  output logic              stall_pc,
  output logic              stall_IF_ID,
  output logic              flush_IF_ID,
  output logic              stall_ID_EX,
  output logic              flush_ID_EX,
  output logic              bubble_EX_MEM,
  output logic              md_busy,
  output logic              md_timeout,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             load_use;
  logic             wd_last;

  // A load in EX whose destination feeds a register the ID instruction actually reads.
  assign load_use = mem_read_EX && (rd_EX != 5'd0) &&
                    ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                     (rs2_used_ID && (rs2_ID == rd_EX)));

  assign wd_last = (wd_cnt == CNT_W'(MD_TIMEOUT - 1));

  // Zero-latency control decode from current state and pipeline inputs.
  always_comb begin
    stall_pc      = 1'b0;
    stall_IF_ID   = 1'b0;
    flush_IF_ID   = 1'b0;
    stall_ID_EX   = 1'b0;
    flush_ID_EX   = 1'b0;
    bubble_EX_MEM = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (md_start_EX && !md_done) begin
            stall_pc      = 1'b1;
            stall_IF_ID   = 1'b1;
            stall_ID_EX   = 1'b1;
            bubble_EX_MEM = 1'b1;
          end else if (redirect_EX) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end else if (!imem_ready) begin
            stall_pc    = 1'b1;
            flush_IF_ID = 1'b1;
          end
        end
        MD_WAIT: begin
          // Other hazards are ignored here; a held redirect acts once back in RUN.
          if (!md_done && !wd_last) begin
            stall_pc      = 1'b1;
            stall_IF_ID   = 1'b1;
            stall_ID_EX   = 1'b1;
            bubble_EX_MEM = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Mul/div sequencing FSM with watchdog and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      wd_cnt     <= '0;
      md_busy    <= 1'b0;
      md_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (md_start_EX && !md_done) begin
            state   <= MD_WAIT;
            wd_cnt  <= CNT_W'(1);
            md_busy <= 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_done) begin
            state   <= RUN;
            wd_cnt  <= '0;
            md_busy <= 1'b0;
          end else if (wd_last) begin
            state      <= RUN;
            wd_cnt     <= '0;
            md_busy    <= 1'b0;
            md_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= RUN;
          wd_cnt  <= '0;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_pc && (stall_cycles != {PERF_W{1'b1}})) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
`endif

  // The decode never asks a register to hold and clear in the same cycle.
  always_ff @(posedge clk) begin
    assert (!(stall_IF_ID && flush_IF_ID));
    assert (!(stall_ID_EX && flush_ID_EX));
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int PERF_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        rs1_ID, rs2_ID, rd_EX;
  logic              rs1_used_ID, rs2_used_ID, mem_read_EX, redirect_EX;
  logic              md_start_EX, md_done, imem_ready;
  logic              stall_pc, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX;
  logic              bubble_EX_MEM, md_busy, md_timeout;
  logic [PERF_W-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  logic [7:0]        exp_q[$];
  logic [PERF_W-1:0] perf_exp = '0;

  // {stall_pc, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX, bubble_EX_MEM, md_busy, md_timeout}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] S4   = 8'b1101_0100;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] RD   = 8'b0010_1000;
  localparam logic [7:0] IW   = 8'b1010_0000;
  localparam logic [7:0] BSY  = 8'b0000_0010;
  localparam logic [7:0] TO   = 8'b0000_0001;

  hazard_ctrl #(.MD_TIMEOUT(8), .CNT_W(4), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .mem_read_EX(mem_read_EX), .redirect_EX(redirect_EX),
    .md_start_EX(md_start_EX), .md_done(md_done), .imem_ready(imem_ready),
    .stall_pc(stall_pc), .stall_IF_ID(stall_IF_ID), .flush_IF_ID(flush_IF_ID),
    .stall_ID_EX(stall_ID_EX), .flush_ID_EX(flush_ID_EX), .bubble_EX_MEM(bubble_EX_MEM),
    .md_busy(md_busy), .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // One cycle: drive inputs after posedge, queue expectation, compare at negedge.
  task automatic cyc(input string name, input logic r,
                     input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                     input logic [4:0] rd, input logic mr, input logic rdr,
                     input logic mds, input logic mdd, input logic imr,
                     input logic [7:0] exp, input logic chk);
    logic [7:0] e, got;
    @(posedge clk);
    #1;
    rst = r; rs1_ID = a1; rs1_used_ID = u1; rs2_ID = a2; rs2_used_ID = u2;
    rd_EX = rd; mem_read_EX = mr; redirect_EX = rdr;
    md_start_EX = mds; md_done = mdd; imem_ready = imr;
    exp_q.push_back(exp);
    @(negedge clk);
    e   = exp_q.pop_front();
    got = {stall_pc, stall_IF_ID, flush_IF_ID, stall_ID_EX, flush_ID_EX,
           bubble_EX_MEM, md_busy, md_timeout};
    if (chk) begin
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s outputs got=%b want=%b", name, got, e);
      end
      total++;
      if (stall_cycles !== perf_exp) begin
        bad++;
        $display("FAIL %s stall_cycles got=%0d want=%0d", name, stall_cycles, perf_exp);
      end
    end
`ifdef HAZ_PERF_CNT_EN
    if (r) perf_exp = '0;
    else if (e[7] && perf_exp != {PERF_W{1'b1}}) perf_exp = perf_exp + 1;
`endif
  endtask

  task automatic idle(input string name, input logic [7:0] exp);
    cyc(name, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp, 1'b1);
  endtask

  task automatic test_reset;
    cyc("reset0", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE, 1'b0);
    cyc("reset_hold", 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, NONE, 1'b1);
    idle("reset_idle", NONE);
  endtask

  task automatic test_load_use;
    cyc("lu_rs1", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LU, 1'b1);
    cyc("lu_after", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NONE, 1'b1);
    cyc("lu_rd0", 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE, 1'b1);
    cyc("lu_rs2_unused", 1'b0, 5'd3, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE, 1'b1);
    cyc("lu_rs2", 1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LU, 1'b1);
    cyc("lu_rs1_unused", 1'b0, 5'd7, 1'b0, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NONE, 1'b1);
  endtask

  task automatic test_priority;
    cyc("redir_over_lu", 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, RD, 1'b1);
    cyc("lu_over_imem", 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, LU, 1'b1);
    cyc("imem_wait", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IW, 1'b1);
    cyc("redir_over_imem", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RD, 1'b1);
    cyc("md1_redir", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, RD, 1'b1);
    cyc("md1_lu", 1'b0, 5'd4, 1'b0, 5'd4, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, LU, 1'b1);
    cyc("md1_plain", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, NONE, 1'b1);
  endtask

  task automatic test_md_done;
    cyc("md_start", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S4, 1'b1);
    cyc("md_wait1", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S4 | BSY, 1'b1);
    cyc("md_wait_redir", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S4 | BSY, 1'b1);
    cyc("md_wait_lu", 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, S4 | BSY, 1'b1);
    cyc("md_wait4", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, S4 | BSY, 1'b1);
    cyc("md_done", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BSY, 1'b1);
    cyc("md_redir_after", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RD, 1'b1);
    idle("md_idle", NONE);
  endtask

  task automatic test_timeout;
    cyc("to_start", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S4, 1'b1);
    for (int i = 1; i <= 6; i++)
      cyc("to_wait", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S4 | BSY, 1'b1);
    cyc("to_abort", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BSY, 1'b1);
    idle("to_sticky1", TO);
    cyc("to_sticky_lu", 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LU | TO, 1'b1);
    idle("to_sticky2", TO);
  endtask

  task automatic test_reset_mid_wait;
    cyc("rmw_start", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S4 | TO, 1'b1);
    cyc("rmw_wait", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S4 | BSY | TO, 1'b1);
    cyc("rmw_rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, BSY | TO, 1'b1);
    idle("rmw_after", NONE);
    cyc("rmw_restart", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, S4, 1'b1);
    cyc("rmw_done", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, BSY, 1'b1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      logic [4:0] r;
      r = 5'($urandom_range(1, 31));
      cyc("b2b_lu", 1'b0, r, 1'b1, 5'd0, 1'b0, r, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, LU, 1'b1);
      cyc("b2b_iw", 1'b0, r, 1'b1, 5'd0, 1'b0, r, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IW, 1'b1);
      cyc("b2b_rd", 1'b0, r, 1'b1, r, 1'b1, r, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, RD, 1'b1);
    end
    idle("b2b_idle", NONE);
  endtask

  initial begin
    rst = 1'b1; rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
    rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; mem_read_EX = 1'b0; redirect_EX = 1'b0;
    md_start_EX = 1'b0; md_done = 1'b0; imem_ready = 1'b1;
    test_reset;
    test_load_use;
    test_priority;
    test_md_done;
    test_timeout;
    test_reset_mid_wait;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
